// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter with MSB/LSB-first selection and valid/ready intake.
// Optional trailing parity bit when the PARITY_EN macro is defined.
module serial_shift_tx #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         dir,
`ifdef PARITY_EN
  input  logic         parity_odd,
`endif
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  cnt;
  logic           dir_q;
  logic           accept;
  logic           last_bit;
`ifdef PARITY_EN
  logic           par_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; every output is a pure function of state/datapath
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = (cnt == CW'(N - 1));
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = dir_q ? sreg[0] : sreg[N-1];
        if (last_bit) begin
`ifdef PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_IDLE;
          done      = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      ST_PAR: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        sout       = par_q;
        state_nxt  = ST_IDLE;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register, bit counter and per-word settings captured at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
`ifdef PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      sreg  <= in_data;
      cnt   <= '0;
      dir_q <= dir;
`ifdef PARITY_EN
      par_q <= (^in_data) ^ parity_odd;
`endif
    end else if (state == ST_SHIFT) begin
      sreg <= dir_q ? {1'b0, sreg[N-1:1]} : {sreg[N-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_shift_tx.sv
// Randomised and directed checks of serial_shift_tx against a bit-queue reference model.
// Build with PARITY_EN defined to exercise the parity variant.
module tb_serial_shift_tx;

  localparam int unsigned N = 8;
`ifdef PARITY_EN
  localparam int unsigned L  = N + 1;
  localparam bit          PE = 1'b1;
`else
  localparam int unsigned L  = N;
  localparam bit          PE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         dir;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;
`ifdef PARITY_EN
  logic         parity_odd;
`endif
  logic [4:0]   obs;

  int           n_cmp = 0;
  int           n_bad = 0;
  bit           q[$];
  logic [31:0]  cap;
  int           ncap;
  int           ndone;

  always #5 clk = ~clk;

  serial_shift_tx #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .dir        (dir),
`ifdef PARITY_EN
    .parity_odd (parity_odd),
`endif
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  assign obs = {in_ready, busy, sout_valid, done, sout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {in_ready, busy, sout_valid, done, sout} for the current cycle
  function automatic logic [4:0] model_outs();
    if (q.size() == 0) return 5'b10000;
    return {1'b0, 1'b1, 1'b1, (q.size() == 1), q[0]};
  endfunction

  // One clock: check outputs, drive inputs for the coming edge, advance the model
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic dr, input logic po);
    @(negedge clk);
    check_eq("outs", 32'(obs), 32'(model_outs()));
    if (sout_valid) begin
      cap = {cap[30:0], sout};
      ncap++;
      if (done) ndone++;
    end
    in_valid = v;
    in_data  = d;
    dir      = dr;
`ifdef PARITY_EN
    parity_odd = po;
`endif
    @(posedge clk);
    if (q.size() == 0) begin
      if (v) begin
        for (int i = 0; i < int'(N); i++) begin
          q.push_back(dr ? d[i] : d[N-1-i]);
        end
`ifdef PARITY_EN
        q.push_back((^d) ^ po);
`endif
      end
    end else begin
      void'(q.pop_front());
    end
  endtask

  task automatic begin_word();
    cap   = '0;
    ncap  = 0;
    ndone = 0;
  endtask

  task automatic junk_cycle();
    cycle(1'b0, N'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic send(input logic [N-1:0] d, input logic dr, input logic po);
    cycle(1'b1, d, dr, po);
    repeat (L) junk_cycle();
  endtask

  // Asynchronous reset pulse starting mid-cycle, held across one rising edge
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq(tag, 32'(obs), 32'(5'b10000));
    q.delete();
    @(negedge clk);
    check_eq({tag, "_hold"}, 32'(obs), 32'(5'b10000));
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    dir      = 1'b0;
`ifdef PARITY_EN
    parity_odd = 1'b0;
`endif
    cap = '0; ncap = 0; ndone = 0;
    #1;
    check_eq("reset_state", 32'(obs), 32'(5'b10000));
    @(negedge clk);
    rst = 1'b0;

    // MSB first
    begin_word();
    send(8'h01, 1'b0, 1'b0);
    check_eq("msb_stream", cap, PE ? 32'({8'h01, 1'b1}) : 32'(8'h01));
    check_eq("msb_nbits", 32'(ncap), 32'(L));
    check_eq("msb_done", 32'(ndone), 32'd1);
    junk_cycle();

    // LSB first
    begin_word();
    send(8'h01, 1'b1, 1'b0);
    check_eq("lsb_stream", cap, PE ? 32'({8'h80, 1'b1}) : 32'(8'h80));
    check_eq("lsb_done", 32'(ndone), 32'd1);

    // Back-to-back with in_valid held high
    begin_word();
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    repeat (L) cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0, 1'b0);
    repeat (L) junk_cycle();
    check_eq("b2b_stream", cap,
             PE ? 32'({8'hF0, 1'b0, 8'h0F, 1'b0}) : 32'({8'hF0, 8'h0F}));
    check_eq("b2b_done", 32'(ndone), 32'd2);

    // Reset during the third bit of a word
    begin_word();
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'hFF, 1'b0, 1'b0);
    reset_pulse("rst_mid");
    repeat (L) junk_cycle();
    check_eq("rst_no_done", 32'(ndone), 32'd0);
    begin_word();
    send(8'h3C, 1'b0, 1'b1);
    check_eq("rst_resume", cap, PE ? 32'({8'h3C, 1'b1}) : 32'(8'h3C));

    // Inputs changed while busy are ignored
    begin_word();
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    repeat (L) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("busy_ignore", cap, PE ? 32'({8'hAA, 1'b0}) : 32'(8'hAA));

    // Parity polarity (data-only stream when parity is not built in)
    begin_word();
    send(8'h07, 1'b0, 1'b0);
    check_eq("par_even", cap, PE ? 32'({8'h07, 1'b1}) : 32'(8'h07));
    check_eq("par_even_n", 32'(ncap), 32'(L));
    begin_word();
    send(8'h07, 1'b0, 1'b1);
    check_eq("par_odd", cap, PE ? 32'({8'h07, 1'b0}) : 32'(8'h07));

    // Random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse("rst_rand");
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), N'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    repeat (L + 1) junk_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
